// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and the fetch queue entry type
package fetch_pkg;

  localparam int          INST_W   = 32;
  localparam logic [31:0] PC_INC   = 32'd4;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry FIFO of fetched {pc, inst} words with flush
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t entry,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head,
  output logic         empty,
  output logic         full
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Storage and pointers; flush drops everything including a same-cycle push,
  // while a same-cycle pop is simply absorbed by the flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= entry;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage (PC, 1-cycle memory read, queue to decode); option FETCH_MISALIGN_TRAP_EN
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          DEPTH    = 2,
  parameter int          ADDR_W   = 10
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] inst_ain,
  input  logic [31:0] inst_dout,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic          inflight;
  logic [CW-1:0] count;
  logic [CW:0]   credit_use;
  logic          deq;
  logic          issue;
  logic          push;
  logic          empty;
  logic          full;
  logic          fault_q;
  logic [31:0]   target;
  fetch_entry_t  head;
  fetch_entry_t  entry;

`ifdef FETCH_MISALIGN_TRAP_EN
  // Misaligned redirect raises the fault; only an aligned redirect clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)              fault_q <= 1'b0;
    else if (redirect_valid) fault_q <= (redirect_pc[1:0] != 2'b00);
  end
  assign target = redirect_pc;
`else
  assign fault_q = 1'b0;
  assign target  = redirect_pc & 32'hFFFF_FFFC;
`endif

  assign fetch_fault = fault_q;
  assign inst_ain    = {{(32-ADDR_W){1'b0}}, pc[ADDR_W+1:2]};
  assign if_valid    = ~empty;
  assign if_inst     = head.inst;
  assign if_pc       = head.pc;
  assign deq         = if_valid & if_ready;

  // Entries already queued plus the one in flight must leave room for a new read.
  assign credit_use  = {1'b0, count} - (CW+1)'(deq) + (CW+1)'(inflight);
  assign issue       = ~redirect_valid & ~fault_q & (credit_use < (CW+1)'(DEPTH));
  assign push        = inflight & ~redirect_valid & (~full | deq);
  assign entry       = '{pc: req_pc, inst: inst_dout};

  // PC and in-flight tracking; a redirect cancels the current read and reloads the PC.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= target;
      inflight <= 1'b0;
    end else if (issue) begin
      pc       <= pc + PC_INC;
      req_pc   <= pc;
      inflight <= 1'b1;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .entry (entry),
    .pop   (deq),
    .flush (redirect_valid),
    .count (count),
    .head  (head),
    .empty (empty),
    .full  (full)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against an in-order delivery model
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic [31:0] inst_ain;
  logic [31:0] inst_dout;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;

  logic [31:0] mem [1024];
  logic [31:0] exp_pc;
  logic [31:0] last_pc;
  logic        faulted;
  int          checks;
  int          errors;
  int          delivered;

  fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .inst_ain       (inst_ain),
    .inst_dout      (inst_dout),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) inst_dout <= mem[inst_ain[9:0]];

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, score any handshake against the expected stream, advance.
  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    chk1("fetch_fault", fetch_fault, faulted);
    if (faulted) chk1("fault_quiet", if_valid, 1'b0);
    if (if_valid && rdy) begin
      chk("if_pc", if_pc, exp_pc);
      chk("if_inst", if_inst, mem[exp_pc[11:2]]);
      last_pc   = if_pc;
      exp_pc    = exp_pc + 32'd4;
      delivered++;
    end
    if (rv) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      exp_pc  = rpc;
      faulted = (rpc[1:0] != 2'b00);
`else
      exp_pc  = {rpc[31:2], 2'b00};
`endif
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wait_deliver(input string tag, input logic [31:0] want);
    int d0 = delivered;
    int n  = 0;
    while (delivered == d0 && n < 20) begin
      cyc(1'b1, 1'b0, 32'h0);
      n++;
    end
    chk1({tag, "_timeout"}, (delivered != d0), 1'b1);
    chk({tag, "_pc"}, last_pc, want);
  endtask

  initial begin
    checks = 0; errors = 0; delivered = 0;
    exp_pc = 32'h0; last_pc = 32'h0; faulted = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    reset = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(posedge clock);
    #1;

    // Reset state
    chk1("rst_valid", if_valid, 1'b0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk1("rst_fault", fetch_fault, 1'b0);
    chk("rst_ain", inst_ain, 32'h0);

    // Release: first valid two cycles later, addresses step by one word
    reset = 1'b1;
    chk("ain_c0", inst_ain, 32'd0);
    chk1("valid_c0", if_valid, 1'b0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("ain_c1", inst_ain, 32'd1);
    chk1("valid_c1", if_valid, 1'b0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("ain_c2", inst_ain, 32'd2);
    chk1("valid_c2", if_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 32'h0);
      chk1("stream_valid", if_valid, 1'b1);
    end

    // Stall: head holds, fetch stops DEPTH words past the head
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 32'h0);
      chk1("stall_valid", if_valid, 1'b1);
      chk("stall_hold_pc", if_pc, exp_pc);
    end
    chk("stall_ain", inst_ain, ((exp_pc + 32'd8) >> 2) & 32'h3FF);
    cyc(1'b0, 1'b0, 32'h0);
    chk("stall_ain_still", inst_ain, ((exp_pc + 32'd8) >> 2) & 32'h3FF);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0);

    // Redirect with a read in flight: target shows up at t+3, nothing stale
    cyc(1'b0, 1'b1, 32'h40);
    chk1("redir_t1_valid", if_valid, 1'b0);
    cyc(1'b1, 1'b0, 32'h0);
    chk1("redir_t2_valid", if_valid, 1'b0);
    cyc(1'b1, 1'b0, 32'h0);
    chk1("redir_t3_valid", if_valid, 1'b1);
    cyc(1'b1, 1'b0, 32'h0);
    chk("redir_target", last_pc, 32'h40);

    // Redirect in the same cycle as a handshake
    cyc(1'b1, 1'b0, 32'h0);
    chk1("hs_valid", if_valid, 1'b1);
    cyc(1'b1, 1'b1, 32'h100);
    wait_deliver("redir_hs", 32'h100);

    // Address wrap at the top of the 1024-word memory
    cyc(1'b1, 1'b1, 32'hFFC);
    chk("wrap_ain_top", inst_ain, 32'd1023);
    cyc(1'b1, 1'b0, 32'h0);
    chk("wrap_ain_zero", inst_ain, 32'd0);
    wait_deliver("wrap_first", 32'hFFC);
    wait_deliver("wrap_second", 32'h1000);

    // Misaligned redirect
    cyc(1'b1, 1'b1, 32'h42);
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 32'h0);
    chk1("fault_held", fetch_fault, 1'b1);
    cyc(1'b1, 1'b1, 32'h80);
    chk1("fault_cleared", fetch_fault, 1'b0);
    wait_deliver("fault_resume", 32'h80);
`else
    wait_deliver("misalign_resume", 32'h40);
`endif

    // Randomized traffic with occasional redirects
    begin
      int d0 = delivered;
      for (int i = 0; i < 400; i++) begin
        logic        rdy = ($urandom_range(0, 3) != 0);
        logic        rv  = ($urandom_range(0, 24) == 0);
        logic [31:0] rpc = $urandom & 32'h0000_1FFF;
        cyc(rdy, rv, rpc);
      end
      chk1("random_progress", (delivered - d0 > 100), 1'b1);
    end
    cyc(1'b1, 1'b1, 32'h200);
    wait_deliver("random_tail", 32'h200);

    // Reset in mid-operation clears state at once
    cyc(1'b1, 1'b0, 32'h0);
    #3;
    reset = 1'b0;
    #1;
    chk1("midrst_valid", if_valid, 1'b0);
    chk("midrst_pc", if_pc, 32'h0);
    chk("midrst_inst", if_inst, 32'h0);
    chk("midrst_ain", inst_ain, 32'h0);
    exp_pc = 32'h0; faulted = 1'b0;
    if_ready = 1'b1; redirect_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    wait_deliver("post_reset", 32'h0);
    wait_deliver("post_reset_next", 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
